// File: rtl/keypad_event_fifo.sv
// keypad_event_fifo
//   Turns the 16-bit debounced key-press pulse vector into an ordered queue
//   of 4-bit key codes. A pending register holds presses that have not yet
//   been queued. Several presses in the same cycle drain from pending into
//   the FIFO one per cycle, lowest key index first. The FIFO is show-ahead,
//   so the bus wrapper reads one key per access.
// Ports
//   clk, rstn   clock, asynchronous active-low reset
//   key_pulse   one-cycle press pulses, bit i = key i
//   pop         read strobe; removes the head entry when not empty
//   clr_ovf     clears the sticky overflow flag
//   dout        head key code, 4'h0 when empty
//   empty/full  registered FIFO state flags
//   count       entries held, 0..DEPTH
//   overflow    sticky: a press was coalesced into one still pending
//   irq         ~empty | overflow
module keypad_event_fifo #(
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic [15:0]   key_pulse,
  input  logic          pop,
  input  logic          clr_ovf,
  output logic [3:0]    dout,
  output logic          empty,
  output logic          full,
  output logic [AW:0]   count,
  output logic          overflow,
  output logic          irq
);

  logic [15:0]   pending;
  logic [15:0]   lowest;
  logic [15:0]   grant;
  logic [3:0]    code;
  logic          push_ok;
  logic          do_pop;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count_nxt;
  logic [3:0]    mem [DEPTH];

  // Isolate the lowest set bit: x & -x.
  assign lowest  = pending & (~pending + 16'd1);
  // A full FIFO can still accept a push in a cycle where it is being popped.
  assign push_ok = (pending != 16'h0) && (!full || pop);
  assign grant   = push_ok ? lowest : 16'h0;
  assign do_pop  = pop && !empty;

  always_comb begin
    code = 4'h0;
    for (int i = 0; i < 16; i++)
      if (lowest[i]) code = 4'(i);
  end

  always_comb begin
    count_nxt = count;
    case ({push_ok, do_pop})
      2'b10:   count_nxt = count + 1'b1;
      2'b01:   count_nxt = count - 1'b1;
      default: count_nxt = count;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pending  <= 16'h0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      empty    <= 1'b1;
      full     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      pending <= (pending & ~grant) | key_pulse;
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count_nxt;
      empty <= (count_nxt == '0);
      full  <= (count_nxt == (AW+1)'(DEPTH));
      // A repeat press of a key that is still pending and not leaving this
      // cycle is merged into the existing entry. Setting the flag has
      // priority over clearing it.
      if (|(key_pulse & pending & ~grant)) overflow <= 1'b1;
      else if (clr_ovf)                    overflow <= 1'b0;
    end
  end

  // Storage needs no reset: dout is forced to 0 while empty.
  always_ff @(posedge clk)
    if (push_ok) mem[wr_ptr] <= code;

  assign dout = empty ? 4'h0 : mem[rd_ptr];
  assign irq  = ~empty | overflow;

endmodule

// File: tb/tb_keypad_event_fifo.sv
module tb_keypad_event_fifo;

  logic        clk = 1'b0;
  logic        rstn;
  logic [15:0] key_pulse;
  logic        pop;
  logic        clr_ovf;
  logic [3:0]  dout;
  logic        empty;
  logic        full;
  logic [3:0]  count;
  logic        overflow;
  logic        irq;

  int n_cmp = 0;
  int n_bad = 0;
  logic [3:0] exp_q[$];

  keypad_event_fifo #(.DEPTH(8), .AW(3)) dut (
    .clk(clk), .rstn(rstn), .key_pulse(key_pulse), .pop(pop),
    .clr_ovf(clr_ovf), .dout(dout), .empty(empty), .full(full),
    .count(count), .overflow(overflow), .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic push_exp(input logic [15:0] keys);
    for (int i = 0; i < 16; i++)
      if (keys[i]) exp_q.push_back(4'(i));
  endtask

  task automatic pulse(input logic [15:0] keys);
    key_pulse = keys;
    tick();
    key_pulse = 16'h0;
  endtask

  // Pop until empty with a cycle budget; the monitor checks each popped code.
  task automatic drain(input string name);
    int n = 0;
    pop = 1'b1;
    while (!empty && n < 40) begin
      tick();
      n++;
    end
    pop = 1'b0;
    chk({name, "_drain_empty"}, empty, 1'b1);
    chk({name, "_drain_q_left"}, exp_q.size(), 0);
  endtask

  // Monitor: each accepted pop is checked against the scoreboard head.
  always @(negedge clk) begin
    if (rstn && pop && !empty) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL pop_unexpected: got %0h expected no entry", dout);
      end else begin
        chk("pop_dout", dout, exp_q.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rstn = 1'b0; key_pulse = 16'h0; pop = 1'b0; clr_ovf = 1'b0;
    #12;
    chk("rst_empty", empty, 1'b1);
    chk("rst_count", count, 0);
    chk("rst_irq", irq, 1'b0);
    rstn = 1'b1;
    tick();

    // Single key 5: visible two edges after the pulse
    key_pulse = 16'h0020; push_exp(16'h0020);
    tick();
    key_pulse = 16'h0;
    chk("single_lat1_empty", empty, 1'b1);
    tick();
    chk("single_empty", empty, 1'b0);
    chk("single_dout", dout, 4'h5);
    chk("single_count", count, 1);
    chk("single_irq", irq, 1'b1);
    pop = 1'b1; tick(); pop = 1'b0;
    chk("single_pop_empty", empty, 1'b1);
    chk("single_pop_dout", dout, 4'h0);
    chk("single_pop_irq", irq, 1'b0);

    // Simultaneous keys 0, 8, 15 serialise lowest first
    push_exp(16'h8101);
    pulse(16'h8101);
    tick(); chk("simul_count1", count, 1);
    tick(); chk("simul_count2", count, 2);
    tick(); chk("simul_count3", count, 3);
    chk("simul_head", dout, 4'h0);
    pop = 1'b1; ticks(3); pop = 1'b0;
    chk("simul_empty", empty, 1'b1);

    // Ten keys into an 8-deep FIFO; 8 and 9 wait in pending
    push_exp(16'h03FF);
    pulse(16'h03FF);
    ticks(12);
    chk("bp_full", full, 1'b1);
    chk("bp_count", count, 8);
    chk("bp_overflow", overflow, 1'b0);
    pop = 1'b1; ticks(2); pop = 1'b0;
    chk("bp_refill_count", count, 8);
    drain("bp");

    // Pop when empty is ignored
    pop = 1'b1; tick(); pop = 1'b0;
    chk("empty_pop_count", count, 0);
    chk("empty_pop_ovf", overflow, 1'b0);

    // Full with simultaneous push and pop; write pointer wraps
    push_exp(16'h00FF);
    pulse(16'h00FF);
    ticks(10);
    chk("fpp_full", full, 1'b1);
    exp_q.push_back(4'hA);
    pulse(16'h0400);
    chk("fpp_held_count", count, 8);
    pop = 1'b1; tick(); pop = 1'b0;
    chk("fpp_count", count, 8);
    chk("fpp_full2", full, 1'b1);
    chk("fpp_head", dout, 4'h1);
    drain("fpp");

    // Loss: key 3 pressed twice while pending behind a full FIFO
    push_exp(16'hFF00);
    pulse(16'hFF00);
    ticks(10);
    chk("loss_full", full, 1'b1);
    exp_q.push_back(4'h3);
    key_pulse = 16'h0008; tick();
    chk("loss_first_ovf", overflow, 1'b0);
    key_pulse = 16'h0008; tick();
    key_pulse = 16'h0;
    chk("loss_ovf", overflow, 1'b1);
    chk("loss_count", count, 8);
    clr_ovf = 1'b1; key_pulse = 16'h0008; tick();
    key_pulse = 16'h0;
    chk("loss_clr_race", overflow, 1'b1);
    tick(); clr_ovf = 1'b0;
    chk("loss_clr", overflow, 1'b0);
    drain("loss");
    ticks(3);
    chk("loss_single3", count, 0);

    // Mid-queue asynchronous reset discards queue and pending
    pulse(16'h8011);
    ticks(2);
    key_pulse = 16'h0010; tick();
    key_pulse = 16'h0010; tick();
    key_pulse = 16'h0;
    #2 rstn = 1'b0;
    #1;
    exp_q.delete();
    chk("mid_rst_empty", empty, 1'b1);
    chk("mid_rst_count", count, 0);
    chk("mid_rst_dout", dout, 4'h0);
    chk("mid_rst_ovf", overflow, 1'b0);
    chk("mid_rst_irq", irq, 1'b0);
    #3 rstn = 1'b1;
    ticks(4);
    chk("mid_rst_pending_gone", empty, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
